// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, oversampling
// constants and the 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  // The sample-point constants below assume 16 ticks per bit.
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;
  localparam int DATA_BITS  = 8;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: divides clk by CLK_FREQ/(BAUD*TICKS_PER_BIT)
// and emits a one-clock tick at the end of each division period. A clear
// re-phases the divider so the first tick of a frame lands a full period
// after the start edge.
module uart_rx_tick #(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD          = 115200,
  parameter int TICKS_PER_BIT = uart_pkg::OVERSAMPLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DIV   = CLK_FREQ / (BAUD * TICKS_PER_BIT);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divisor counter, synchronously cleared for phase alignment.
  // NOTE: state flops take non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receiver in the clk_50m domain. Synchronises rx, detects the
// start edge, samples each bit mid-cell with a 16x tick and presents the
// byte with rdy / frame_err / overrun status.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote over samples at
// scnt 7, 8 and 9 instead of a single sample at scnt 8.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk_50m,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       rdy_clr,
  output logic [7:0] data_out,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic [3:0] S_MID = 4'(SAMPLE_MID);

  rx_state_e        state, state_nxt;
  logic             sync_ff, rx_s, prev_rx;
  logic [1:0]       sync_valid;
  logic             armed;
  logic             start_edge, tick, sample_pt, bit_val;
  logic [3:0]       scnt;
  logic [IDX_W-1:0] bit_idx;
  logic [7:0]       shreg;
  logic             shift_en, load_byte, set_ferr;

  // Two-flop synchroniser plus edge history; armed ensures the line has
  // really been seen high (not just the reset value) before a start counts.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff    <= 1'b1;
      rx_s       <= 1'b1;
      prev_rx    <= 1'b1;
      sync_valid <= '0;
      armed      <= 1'b0;
    end else begin
      sync_ff    <= rx;
      rx_s       <= sync_ff;
      prev_rx    <= rx_s;
      sync_valid <= {sync_valid[0], 1'b1};
      armed      <= armed | (sync_valid[1] & rx_s);
    end
  end

  assign start_edge = (state == IDLE) && armed && prev_rx && !rx_s;

  uart_rx_tick #(
    .CLK_FREQ     (CLK_FREQ),
    .BAUD         (BAUD),
    .TICKS_PER_BIT(OVERSAMPLE)
  ) u_tick (
    .clk  (clk_50m),
    .rst_n(reset_n),
    .clear(start_edge),
    .tick (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] S_LO = 4'(SAMPLE_LO);
  localparam logic [3:0] S_HI = 4'(SAMPLE_HI);
  logic s_lo, s_mid;

  // Hold the two early votes; the third is rx_s at the decision tick.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      s_lo  <= 1'b1;
      s_mid <= 1'b1;
    end else if (tick) begin
      if (scnt == S_LO)  s_lo  <= rx_s;
      if (scnt == S_MID) s_mid <= rx_s;
    end
  end

  assign sample_pt = tick && (scnt == S_HI);
  assign bit_val   = majority3(s_lo, s_mid, rx_s);
`else
  assign sample_pt = tick && (scnt == S_MID);
  assign bit_val   = rx_s;
`endif

  // FSM state register.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath strobes.
  // NOTE: every output of this block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    set_ferr  = 1'b0;
    unique case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (sample_pt)  state_nxt = bit_val ? IDLE : DATA;
      DATA: begin
        if (sample_pt) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_IDX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (sample_pt) begin
          state_nxt = IDLE;
          load_byte = bit_val;
          set_ferr  = !bit_val;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sample counter, bit index and LSB-first shift register.
  // NOTE: shreg and bit_idx are reset even though each frame overwrites
  // them before use; it keeps simulation X-free and costs nothing here.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      scnt    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (start_edge)  scnt <= '0;
      else if (tick)   scnt <= scnt + 1'b1;
      if (start_edge)  bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      if (shift_en)    shreg <= {bit_val, shreg[7:1]};
    end
  end

  // Output registers; a completing byte wins over a same-cycle rdy_clr.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (load_byte) begin
      data_out  <= shreg;
      rdy       <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= rdy && !rdy_clr;
    end else begin
      if (set_ferr) frame_err <= 1'b1;
      if (rdy_clr) begin
        rdy     <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver. Frames are driven at exactly
// 16*DIV clocks per bit; expected bytes go into a scoreboard queue when a
// frame is driven and are popped when the receiver completes it.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / (BAUD * 16);
  localparam int BIT_CYC  = 16 * DIV;
`ifdef UART_RX_MAJORITY_EN
  localparam int SAMP_TICK = 10;
`else
  localparam int SAMP_TICK = 9;
`endif
  // Negedge index (start edge driven at index 0) just before the clock edge
  // on which the stop-bit decision updates the outputs.
  localparam int E_DONE  = 2 + DIV * (SAMP_TICK + 16 * 9);
  localparam int E_START = 2 + DIV * SAMP_TICK;
  // One-clock spike aligned to the scnt==8 sample of data bit 2.
  localparam int SPIKE_C = DIV * (9 + 16 * 3);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       rdy_clr;
  logic [7:0] data_out;
  logic       rdy, frame_err, overrun, rx_busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  logic [7:0] m_data;
  logic       m_rdy, m_ferr, m_ovr;
  logic [7:0] obs_data;
  logic       obs_busy_done, obs_busy_after, obs_rdy_done, obs_rdy_after;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .clk_50m  (clk),
    .reset_n  (reset_n),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .data_out (data_out),
    .rdy      (rdy),
    .frame_err(frame_err),
    .overrun  (overrun),
    .rx_busy  (rx_busy)
  );

  always #10 clk = ~clk;

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got cycle budget exhausted, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  // Drive one full frame; records outputs around the stop decision.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic spike, input logic clr_done);
    logic [9:0]  bits;
    logic [7:0]  eb;
    bits = {stop_bit, b, 1'b0};
    eb   = b;
`ifndef UART_RX_MAJORITY_EN
    if (spike) eb[2] = 1'b0;
`endif
    if (stop_bit) begin
      exp_q.push_back(eb);
      m_data = eb;
      m_ovr  = m_rdy && !clr_done;
      m_rdy  = 1'b1;
      m_ferr = 1'b0;
    end else begin
      m_ferr = 1'b1;
      if (clr_done) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
    end
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      @(negedge clk);
      rx = bits[c / BIT_CYC];
      if (spike && (c == SPIKE_C)) rx = 1'b0;
      rdy_clr = clr_done && (c == E_DONE);
      if (c == E_DONE) begin
        obs_busy_done = rx_busy;
        obs_rdy_done  = rdy;
      end
      if (c == E_DONE + 1) begin
        obs_busy_after = rx_busy;
        obs_rdy_after  = rdy;
        obs_data       = data_out;
      end
    end
    rdy_clr = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk) rdy_clr = 1'b1;
    @(negedge clk) rdy_clr = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rx = 1'b1; rdy_clr = 1'b0; reset_n = 1'b0;
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, rdy, frame_err, overrun, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_in: got %h expected 000", {data_out, rdy, frame_err, overrun, rx_busy});
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({data_out, rdy, frame_err, overrun, rx_busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_out: got %h expected 000", {data_out, rdy, frame_err, overrun, rx_busy});
    end
  endtask

  task automatic test_clean_byte();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if (obs_data !== exp_b) begin
      errors++; $display("FAIL clean_data: got %h expected %h", obs_data, exp_b);
    end
    checks++;
    if ({obs_rdy_done, obs_rdy_after} !== 2'b01) begin
      errors++; $display("FAIL clean_rdy_latency: got %b expected 01", {obs_rdy_done, obs_rdy_after});
    end
    checks++;
    if ({obs_busy_done, obs_busy_after} !== 2'b10) begin
      errors++; $display("FAIL clean_busy_fall: got %b expected 10", {obs_busy_done, obs_busy_after});
    end
    checks++;
    if ({frame_err, overrun} !== {m_ferr, m_ovr}) begin
      errors++; $display("FAIL clean_flags: got %b expected %b", {frame_err, overrun}, {m_ferr, m_ovr});
    end
    idle(20);
  endtask

  task automatic test_glitch();
    logic busy_mid, busy_pre, busy_post;
    busy_mid = 1'b0; busy_pre = 1'b0; busy_post = 1'b1;
    for (int c = 0; c < E_START + 100; c++) begin
      @(negedge clk);
      rx = (c < 4 * DIV) ? 1'b0 : 1'b1;
      if (c == 20)          busy_mid  = rx_busy;
      if (c == E_START)     busy_pre  = rx_busy;
      if (c == E_START + 1) busy_post = rx_busy;
    end
    checks++;
    if ({busy_mid, busy_pre, busy_post} !== 3'b110) begin
      errors++; $display("FAIL glitch_busy: got %b expected 110", {busy_mid, busy_pre, busy_post});
    end
    checks++;
    if ({data_out, rdy, frame_err, overrun} !== {m_data, m_rdy, m_ferr, m_ovr}) begin
      errors++;
      $display("FAIL glitch_flags: got %h expected %h", {data_out, rdy, frame_err, overrun}, {m_data, m_rdy, m_ferr, m_ovr});
    end
    idle(20);
  endtask

  task automatic test_framing_error();
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if (obs_data !== exp_b) begin
      errors++; $display("FAIL ferr_prev_data: got %h expected %h", obs_data, exp_b);
    end
    idle(20);
    pulse_clr();
    checks++;
    if ({rdy, overrun} !== 2'b00) begin
      errors++; $display("FAIL ferr_ack: got %b expected 00", {rdy, overrun});
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    idle(20);
    checks++;
    if ({data_out, rdy, frame_err, overrun, rx_busy} !== {m_data, m_rdy, m_ferr, m_ovr, 1'b0}) begin
      errors++;
      $display("FAIL ferr_flags: got %h expected %h", {data_out, rdy, frame_err, overrun, rx_busy}, {m_data, m_rdy, m_ferr, m_ovr, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, 1'b0, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if (obs_data !== exp_b) begin
      errors++; $display("FAIL b2b_first: got %h expected %h", obs_data, exp_b);
    end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if ({obs_data, rdy, overrun, frame_err} !== {exp_b, m_rdy, m_ovr, m_ferr}) begin
      errors++;
      $display("FAIL b2b_overrun: got %h expected %h", {obs_data, rdy, overrun, frame_err}, {exp_b, m_rdy, m_ovr, m_ferr});
    end
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    exp_b = exp_q.pop_front();
    idle(5);
    checks++;
    if ({obs_data, rdy, overrun} !== {exp_b, m_rdy, m_ovr}) begin
      errors++;
      $display("FAIL b2b_collision: got %h expected %h", {obs_data, rdy, overrun}, {exp_b, m_rdy, m_ovr});
    end
    idle(20);
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] bits;
    logic       busy_seen;
    bits = {1'b1, 8'h96, 1'b0};
    for (int c = 0; c < 5 * BIT_CYC + BIT_CYC / 2; c++) begin
      @(negedge clk);
      rx = bits[c / BIT_CYC];
    end
    checks++;
    if (rx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_busy: got %b expected 1", rx_busy);
    end
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({data_out, rdy, frame_err, overrun, rx_busy} !== 12'h000) begin
      errors++; $display("FAIL mid_async_reset: got %h expected 000", {data_out, rdy, frame_err, overrun, rx_busy});
    end
    m_data = 8'h00; m_rdy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    busy_seen = 1'b0;
    repeat (1500) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    checks++;
    if ({busy_seen, rdy} !== 2'b00) begin
      errors++; $display("FAIL low_line_start: got %b expected 00", {busy_seen, rdy});
    end
    idle(40);
    send_frame(8'h55, 1'b1, 1'b0, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if ({obs_data, obs_rdy_after, overrun} !== {exp_b, m_rdy, m_ovr}) begin
      errors++;
      $display("FAIL after_reset_byte: got %h expected %h", {obs_data, obs_rdy_after, overrun}, {exp_b, m_rdy, m_ovr});
    end
    idle(20);
  endtask

  task automatic test_majority_spike();
    pulse_clr();
    idle(20);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    exp_b = exp_q.pop_front();
    checks++;
    if ({obs_data, rdy, overrun} !== {exp_b, m_rdy, m_ovr}) begin
      errors++;
      $display("FAIL spike_data: got %h expected %h", {obs_data, rdy, overrun}, {exp_b, m_rdy, m_ovr});
    end
    idle(20);
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_majority_spike();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- UART receive stage; the mirror of the existing transmitter path.
- Recovers 8N1 frames from a serial line (e.g. looped back from the transmitter's Tx, or an external host) and presents each byte with a ready flag.
- Output bytes are written into the circuit-side FIFO or to LEDs.
- Runs entirely in the clk_50m domain.
- Generates its own 16x-oversample tick; the 16x rate is independent of the transmitter's baud enable.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line bit rate.
- OVERSAMPLE, 16: ticks per bit, fixed at 16 (the sample-point constants depend on it).

Ports:
- clk_50m  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line, asynchronous, idle high.
- rdy_clr  input  1  one-cycle pulse; consumer acknowledges the byte.
- data_out  output  8  last correctly framed byte.
- rdy  output  1  a byte is valid and unacknowledged.
- frame_err  output  1  last frame had a bad stop bit.
- overrun  output  1  a byte completed while rdy was still set.
- rx_busy  output  1  a frame is in progress.

Behaviour:
- Reset (async, reset_n=0): data_out=0x00; rdy, frame_err, overrun and rx_busy = 0; state=IDLE; synchroniser flops=1; prev-rx=1; tick and sample counters=0.
- Input sync: rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer-truncated; 27 at the defaults.
  - Counter runs 0..DIV-1; tick pulses for one clock when the counter is at DIV-1.
  - Counter is forced to 0 on start detection for phase alignment.
- Sample counter: scnt, 4-bit, advances on each tick, wraps 15->0. The sample point is scnt==8.
- FSM:
  - IDLE: on a 1->0 transition of rx_s (prev-rx=1, rx_s=0) -> START; scnt=0; rx_busy=1. A line held low out of reset never starts a frame; it must first be seen high.
  - START: at the sample point, rx_s=0 -> DATA with bit index 0; rx_s=1 -> IDLE and rx_busy=0 (glitch rejected, no flags change).
  - DATA: at each sample point, shift rx_s in LSB-first. After the 8th bit -> STOP.
  - STOP, sample point with rx_s=1: data_out loads the shift register; rdy=1; frame_err=0; overrun=1 if rdy was already 1.
  - STOP, sample point with rx_s=0: frame_err=1; data_out and rdy are unchanged.
  - Either STOP outcome -> IDLE, with rx_busy=0 in the same cycle.
- Latency: rdy rises 1 clk after the stop-bit sample-point tick, about 9.5 bit times after the start edge.
- rdy_clr: clears rdy and overrun on the next clock. If rdy_clr and a byte completion occur in the same cycle, the set wins: rdy=1 and overrun=0 (the old byte was acknowledged).
- frame_err is sticky until the next completed frame, good or bad.
- Reset mid-frame: abandons the frame immediately; no partial byte is ever presented.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit, start bit included, is sampled at scnt 7, 8 and 9; the 2-of-3 majority is the decided value. The decision, shift and transitions occur at scnt==9. All latencies grow by one tick.
- Undefined: single sample at scnt==8, as above.

Decomposition:
- Package uart_pkg:
  - state encoding IDLE/START/DATA/STOP;
  - OVERSAMPLE=16;
  - SAMPLE_MID=8, SAMPLE_LO=7, SAMPLE_HI=9;
  - DATA_BITS=8.
- Sub-module uart_rx_tick: divisor counter with sync-clear input and tick output, parameterised by CLK_FREQ and BAUD.

Test Plan:
- Clean byte: send 0xA5 at 115200 8N1 -> data_out=0xA5, rdy=1, frame_err=0, overrun=0; rx_busy falls at the stop sample point.
- Framing error: previous byte 0x11 is acknowledged (rdy_clr pulsed, rdy=0); send 0x3C with stop bit driven 0 -> frame_err=1, rdy stays 0, data_out stays 0x11.
- Glitch: rx low for 4 ticks (~0.25 bit), then high -> START aborts at the sample point; rx_busy returns to 0; no flag changes.
- Overrun and same-cycle collision:
  - Send 0x00 then 0xFF back-to-back with no rdy_clr -> data_out=0xFF, rdy=1, overrun=1.
  - Pulse rdy_clr in the cycle 0xFF completes -> rdy=1, overrun=0.
- Reset: assert reset_n mid-bit 4 -> all outputs 0 asynchronously.
  - Release with rx held low -> no frame starts.
  - Raise rx, then send 0x55 -> data_out=0x55.
- Majority (macro defined): 1-clock-wide low spike at scnt=8 inside a '1' data bit of 0xFF -> data_out=0xFF. Without the macro, the same stimulus -> corrupted bit, data_out not 0xFF.
